// File: rtl/fluid_pipe.sv
// Elastic valid/retry pipeline built from Depth two-entry skid stages.
// Every stage's retry is a register, so there is no qRetry->dinRetry combinational path.

module fluid_stage #(
  parameter int Size = 8
) (
  input  logic            clk,
  input  logic            i_flush,
  input  logic [Size-1:0] i_din,
  input  logic            i_vld,
  output logic            o_retry,
  output logic [Size-1:0] o_q,
  output logic            o_vld,
  input  logic            i_retry
);
  logic [Size-1:0] r_m, r_s;
  logic            r_m_vld, r_s_vld;
  logic            w_in, w_out;

  assign w_in    = i_vld && !r_s_vld;
  assign w_out   = r_m_vld && !i_retry;
  assign o_retry = r_s_vld;
  assign o_q     = r_m;
  assign o_vld   = r_m_vld;

  always_ff @(posedge clk) begin
    if (i_flush) begin
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else if (w_out) begin
      if (r_s_vld) r_s_vld <= 1'b0;
      else         r_m_vld <= w_in;
    end else if (w_in) begin
      if (r_m_vld) r_s_vld <= 1'b1;
      else         r_m_vld <= 1'b1;
    end
  end

  // Data path carries no reset; stale contents are masked by the valid bits.
  always_ff @(posedge clk) begin
    if (w_out) begin
      if (r_s_vld)   r_m <= r_s;
      else if (w_in) r_m <= i_din;
    end else if (w_in) begin
      if (r_m_vld) r_s <= i_din;
      else         r_m <= i_din;
    end
  end
endmodule

module fluid_pipe #(
  parameter int Size  = 8,
  parameter int Depth = 4,
  parameter int CntW  = $clog2(2*Depth+1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [Size-1:0] din,
  input  logic            dinValid,
  output logic            dinRetry,
  output logic [Size-1:0] q,
  output logic            qValid,
  input  logic            qRetry,
  output logic [CntW-1:0] count,
  output logic            empty
);
  logic                       w_flush;
  logic [Depth:0][Size-1:0]   w_d;
  logic [Depth:0]             w_v, w_r;
  logic                       w_in_xfer, w_out_xfer;
  logic [CntW-1:0]            r_count;

  assign w_flush = reset || clear;

  // Flush masks both ends so no transfer can happen in a flush cycle.
  assign w_d[0]   = din;
  assign w_v[0]   = dinValid && !w_flush;
  assign dinRetry = w_r[0] || w_flush;
  assign w_r[Depth] = qRetry || w_flush;
  assign q        = w_d[Depth];
  assign qValid   = w_v[Depth] && !w_flush;

  for (genvar k = 0; k < Depth; k++) begin : g_stage
    fluid_stage #(.Size(Size)) u_stage (
      .clk     (clk),
      .i_flush (w_flush),
      .i_din   (w_d[k]),
      .i_vld   (w_v[k]),
      .o_retry (w_r[k]),
      .o_q     (w_d[k+1]),
      .o_vld   (w_v[k+1]),
      .i_retry (w_r[k+1])
    );
  end

  assign w_in_xfer  = dinValid && !dinRetry;
  assign w_out_xfer = qValid && !qRetry;

  always_ff @(posedge clk) begin
    if (w_flush) r_count <= '0;
    else         r_count <= r_count + CntW'(w_in_xfer) - CntW'(w_out_xfer);
  end

  assign count = r_count;
  assign empty = (r_count == '0);
endmodule
